alu_instr_sequencer: RTL and testbench

- Hardwired control sequencer that drives the Mini-SRC datapath's control inputs.
- Replaces hand-driven control for register-register ALU, MUL/DIV, NEG/NOT, NOP and HALT instructions.
- Sits directly upstream of the datapath. It consumes the IR contents and a memory-ready handshake, and produces every bus-out, register-in, memory and ALU-opcode strobe one state at a time.

---
 rtl/alu_instr_sequencer_if.sv | 36 +++
 rtl/alu_instr_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_instr_sequencer_if.sv
// Control bundle between the hardwired sequencer and the Mini-SRC datapath.
//   master : sequencer side; takes start/stop/ir/mem_ready and drives every
//            bus-out, register-load, memory and ALU-opcode strobe.
//   slave  : datapath side; the mirror image of master.
interface alu_instr_sequencer_if #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned OPW   = 5
);
    logic             start;
    logic             stop;
    logic [31:0]      ir;
    logic             mem_ready;

    logic             PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
    logic             MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin;
    logic             IncPC, Read;
    logic [NREGS-1:0] R0_15_out;
    logic [NREGS-1:0] R0_15_in;
    logic [OPW-1:0]   opcode;
    logic             halted;
    logic             illegal;

    modport master (
        input  start, stop, ir, mem_ready,
        output PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        output MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin,
        output IncPC, Read, R0_15_out, R0_15_in, opcode, halted, illegal
    );

    modport slave (
        output start, stop, ir, mem_ready,
        input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        input  MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin,
        input  IncPC, Read, R0_15_out, R0_15_in, opcode, halted, illegal
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Hardwired control sequencer for the Mini-SRC datapath. Steps through
// fetch (T0..T2) and execute (T3..T6) for reg-reg ALU, MUL/DIV, NEG/NOT,
// NOP and HALT instructions, raising one state's worth of strobes per cycle.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset, returns to IDLE with all strobes low
//   bus   : master modport of alu_instr_sequencer_if (inputs start, stop, ir,
//           mem_ready; outputs every datapath strobe, halted and illegal)
module alu_instr_sequencer #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned OPW   = 5
) (
    input  logic                  clock,
    input  logic                  clear,
    alu_instr_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu, ClsMulDiv, ClsNegNot, ClsNop, ClsHalt, ClsIllegal
    } cls_e;

    state_e     state_q, state_d;
    cls_e       cls;
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       unused_ir;

    assign opc       = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    always_comb begin
        cls = ClsIllegal;
        case (opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = ClsAlu;
            5'b01111, 5'b10000:                     cls = ClsMulDiv;
            5'b10001, 5'b10010:                     cls = ClsNegNot;
            5'b11010:                               cls = ClsNop;
            5'b11011:                               cls = ClsHalt;
            default:                                cls = ClsIllegal;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.PCout     = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.MDRout    = 1'b0;
        bus.HIout     = 1'b0;
        bus.LOout     = 1'b0;
        bus.MARin     = 1'b0;
        bus.PCin      = 1'b0;
        bus.MDRin     = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zlowin    = 1'b0;
        bus.Zhighin   = 1'b0;
        bus.HIin      = 1'b0;
        bus.LOin      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.Read      = 1'b0;
        bus.R0_15_out = '0;
        bus.R0_15_in  = '0;
        bus.opcode    = '0;
        bus.halted    = 1'b0;
        bus.illegal   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StT0;
            end
            StT0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
                state_d    = StT1;
            end
            StT1: begin
                // Strobes stay up while waiting; reloading PC from Z is harmless.
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_ready) state_d = StT2;
            end
            StT2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                case (cls)
                    ClsAlu, ClsMulDiv: state_d = StT3;
                    ClsNegNot:         state_d = StT4;
                    ClsHalt:           state_d = StHalt;
                    ClsIllegal: begin
                        bus.illegal = 1'b1;
                        state_d     = bus.stop ? StIdle : StT0;
                    end
                    default:           state_d = bus.stop ? StIdle : StT0;
                endcase
            end
            StT3: begin
                bus.Yin       = 1'b1;
                bus.R0_15_out = (cls == ClsMulDiv) ? (NREGS'(1) << ra) : (NREGS'(1) << rb);
                state_d       = StT4;
            end
            StT4: begin
                bus.Zlowin    = 1'b1;
                bus.opcode    = OPW'(opc);
                bus.Zhighin   = (cls == ClsMulDiv);
                bus.R0_15_out = (cls == ClsAlu) ? (NREGS'(1) << rc) : (NREGS'(1) << rb);
                state_d       = StT5;
            end
            StT5: begin
                bus.Zlowout = 1'b1;
                if (cls == ClsMulDiv) begin
                    bus.LOin = 1'b1;
                    state_d  = StT6;
                end else begin
                    bus.R0_15_in = NREGS'(1) << ra;
                    state_d      = bus.stop ? StIdle : StT0;
                end
            end
            StT6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                state_d      = bus.stop ? StIdle : StT0;
            end
            StHalt: begin
                bus.halted = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
module tb_alu_instr_sequencer;

    typedef struct packed {
        logic        chk;
        logic [18:0] ctl;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  op;
    } exp_t;

    localparam int PCOUT = 0, ZLOWOUT = 1, ZHIGHOUT = 2, MDROUT = 3, HIOUT = 4, LOOUT = 5;
    localparam int MARIN = 6, PCIN = 7, MDRIN = 8, IRIN = 9, YIN = 10, ZLOWIN = 11;
    localparam int ZHIGHIN = 12, HIIN = 13, LOIN = 14, INCPC = 15, READ = 16;
    localparam int HALTED = 17, ILLEGAL = 18;

    localparam logic [31:0] SUB_I = 32'h2091_8000;
    localparam logic [31:0] MUL_I = 32'h7918_0000;
    localparam logic [31:0] NEG_I = 32'h8890_0000;
    localparam logic [31:0] ILL_I = 32'hF800_0000;
    localparam logic [31:0] HLT_I = 32'hD800_0000;

    logic clock = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    alu_instr_sequencer_if #(.NREGS(16), .OPW(5)) bus ();

    alu_instr_sequencer #(.NREGS(16), .OPW(5)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    logic [18:0] obs_ctl;
    logic [55:0] obs_all;
    assign obs_ctl = {bus.illegal, bus.halted, bus.Read, bus.IncPC, bus.LOin, bus.HIin,
                      bus.Zhighin, bus.Zlowin, bus.Yin, bus.IRin, bus.MDRin, bus.PCin,
                      bus.MARin, bus.LOout, bus.HIout, bus.MDRout, bus.Zhighout,
                      bus.Zlowout, bus.PCout};
    assign obs_all = {obs_ctl, bus.R0_15_out, bus.R0_15_in, bus.opcode};

    function automatic logic [18:0] b(input int idx);
        logic [18:0] one = 19'd1;
        return one << idx;
    endfunction

    function automatic logic [15:0] sel(input logic [3:0] f);
        logic [15:0] one = 16'd1;
        return one << f;
    endfunction

    function automatic exp_t mk(input logic [18:0] ctl, input logic [15:0] rout,
                                input logic [15:0] rin, input logic [4:0] op);
        return {1'b1, ctl, rout, rin, op};
    endfunction

    // 0 alu, 1 mul/div, 2 neg/not, 3 nop, 4 halt, 5 illegal
    function automatic int classify(input logic [4:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: return 0;
            5'd15, 5'd16: return 1;
            5'd17, 5'd18: return 2;
            5'd26:        return 3;
            5'd27:        return 4;
            default:      return 5;
        endcase
    endfunction

    // Reference: the per-cycle strobe list of one instruction, from T0 to its last state.
    task automatic build(input logic [31:0] ins, input int waits, output exp_t e[$]);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        int         cls;
        exp_t       skip;
        op   = ins[31:27];
        ra   = ins[26:23];
        rb   = ins[22:19];
        rc   = ins[18:15];
        cls  = classify(op);
        skip = '0;
        e    = {};
        e.push_back(mk(b(PCOUT) | b(MARIN) | b(INCPC) | b(ZLOWIN), 0, 0, 0));
        for (int i = 0; i < waits; i++)
            e.push_back(mk(b(ZLOWOUT) | b(PCIN) | b(READ) | b(MDRIN), 0, 0, 0));
        e.push_back(skip);  // data-valid fetch cycle: not compared
        e.push_back(mk(b(MDROUT) | b(IRIN) | ((cls == 5) ? b(ILLEGAL) : 19'd0), 0, 0, 0));
        if (cls == 0) begin
            e.push_back(mk(b(YIN), sel(rb), 0, 0));
            e.push_back(mk(b(ZLOWIN), sel(rc), 0, op));
            e.push_back(mk(b(ZLOWOUT), 0, sel(ra), 0));
        end else if (cls == 1) begin
            e.push_back(mk(b(YIN), sel(ra), 0, 0));
            e.push_back(mk(b(ZLOWIN) | b(ZHIGHIN), sel(rb), 0, op));
            e.push_back(mk(b(ZLOWOUT) | b(LOIN), 0, 0, 0));
            e.push_back(mk(b(ZHIGHOUT) | b(HIIN), 0, 0, 0));
        end else if (cls == 2) begin
            e.push_back(mk(b(ZLOWIN), sel(rb), 0, op));
            e.push_back(mk(b(ZLOWOUT), 0, sel(ra), 0));
        end
    endtask

    // Runs one instruction from T0 (first ncyc cycles, or all when ncyc < 0).
    task automatic play(input logic [31:0] ins, input int waits, input bit stp, input int ncyc,
                        output exp_t eq[$], output exp_t oq[$]);
        exp_t full[$];
        int   n;
        build(ins, waits, full);
        n  = (ncyc < 0) ? full.size() : ncyc;
        eq = {};
        oq = {};
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.ir        = ins;
            bus.mem_ready = (i >= 1 && i <= waits) ? 1'b0 :
                            (i == waits + 1) ? 1'b1 : 1'($urandom);
            if (i == full.size() - 1) begin
                bus.stop  = stp;
                bus.start = stp ? 1'b1 : 1'($urandom);
            end else begin
                bus.stop  = 1'($urandom);
                bus.start = 1'($urandom);
            end
            #1;
            eq.push_back(full[i]);
            oq.push_back({full[i].chk, obs_ctl, bus.R0_15_out, bus.R0_15_in, bus.opcode});
        end
    endtask

    task automatic kick();
        @(negedge clock);
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        bus.start = 1'b1;
        bus.stop = 1'b0;
        bus.mem_ready = 1'b1;
        bus.ir = SUB_I;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (obs_all !== 56'd0) begin
                errors++;
                $display("FAIL reset_outputs got %h exp 0", obs_all);
            end
        end
        @(negedge clock);
        clear = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs_all !== 56'd0) begin
                errors++;
                $display("FAIL idle_outputs got %h exp 0", obs_all);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_sub();
        exp_t eq[$], oq[$];
        kick();
        for (int k = 0; k < 2; k++) begin
            play(SUB_I, 0, 1'b0, -1, eq, oq);
            foreach (eq[i]) if (eq[i].chk) begin
                checks++;
                if (oq[i] !== eq[i]) begin
                    errors++;
                    $display("FAIL sub cyc %0d got %h exp %h", i, oq[i], eq[i]);
                end
            end
        end
        checks++;
        if (oq[3].rout !== 16'h0004 || oq[4].rout !== 16'h0008 || oq[4].op !== 5'b00100 ||
            oq[5].rin !== 16'h0002) begin
            errors++;
            $display("FAIL sub_selects got %h %h %h %h exp 0004 0008 04 0002",
                     oq[3].rout, oq[4].rout, oq[4].op, oq[5].rin);
        end
    endtask

    task automatic test_mem_wait();
        exp_t eq[$], oq[$];
        play(SUB_I, 3, 1'b0, -1, eq, oq);
        foreach (eq[i]) if (eq[i].chk) begin
            checks++;
            if (oq[i] !== eq[i]) begin
                errors++;
                $display("FAIL mem_wait cyc %0d got %h exp %h", i, oq[i], eq[i]);
            end
        end
    endtask

    task automatic test_mul_neg_illegal();
        exp_t eq[$], oq[$];
        play(MUL_I, 0, 1'b0, -1, eq, oq);
        foreach (eq[i]) if (eq[i].chk) begin
            checks++;
            if (oq[i] !== eq[i]) begin
                errors++;
                $display("FAIL mul cyc %0d got %h exp %h", i, oq[i], eq[i]);
            end
        end
        checks++;
        if (oq.size() != 7 || oq[3].rout !== 16'h0004 || oq[6].ctl !== (b(ZHIGHOUT) | b(HIIN)))
        begin
            errors++;
            $display("FAIL mul_shape got len %0d rout %h t6 %h", oq.size(), oq[3].rout, oq[6].ctl);
        end
        play(NEG_I, 1, 1'b0, -1, eq, oq);
        foreach (eq[i]) if (eq[i].chk) begin
            checks++;
            if (oq[i] !== eq[i]) begin
                errors++;
                $display("FAIL neg cyc %0d got %h exp %h", i, oq[i], eq[i]);
            end
        end
        play(ILL_I, 0, 1'b0, -1, eq, oq);
        foreach (eq[i]) if (eq[i].chk) begin
            checks++;
            if (oq[i] !== eq[i]) begin
                errors++;
                $display("FAIL illegal cyc %0d got %h exp %h", i, oq[i], eq[i]);
            end
        end
    endtask

    task automatic test_random();
        exp_t eq[$], oq[$];
        logic [4:0] legal [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                   5'd15, 5'd16, 5'd17, 5'd18, 5'd26};
        logic [4:0]  op;
        logic [31:0] ins;
        int          r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 14);
            if (r < 14) op = legal[r];
            else begin
                op = 5'($urandom);
                while (classify(op) != 5) op = 5'($urandom);
            end
            ins = {op, 27'($urandom)};
            play(ins, $urandom_range(0, 3), 1'b0, -1, eq, oq);
            foreach (eq[i]) if (eq[i].chk) begin
                checks++;
                if (oq[i] !== eq[i]) begin
                    errors++;
                    $display("FAIL random ir %h cyc %0d got %h exp %h", ins, i, oq[i], eq[i]);
                end
            end
        end
    endtask

    task automatic test_stop();
        exp_t eq[$], oq[$];
        play(SUB_I, 0, 1'b1, -1, eq, oq);  // start and stop both high at the boundary
        foreach (eq[i]) if (eq[i].chk) begin
            checks++;
            if (oq[i] !== eq[i]) begin
                errors++;
                $display("FAIL stop cyc %0d got %h exp %h", i, oq[i], eq[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            #1;
            checks++;
            if (obs_all !== 56'd0) begin
                errors++;
                $display("FAIL stop_idle got %h exp 0", obs_all);
            end
        end
        kick();
        play(SUB_I, 0, 1'b0, -1, eq, oq);
        foreach (eq[i]) if (eq[i].chk) begin
            checks++;
            if (oq[i] !== eq[i]) begin
                errors++;
                $display("FAIL restart cyc %0d got %h exp %h", i, oq[i], eq[i]);
            end
        end
    endtask

    task automatic test_halt();
        exp_t eq[$], oq[$];
        play(HLT_I, 1, 1'b0, -1, eq, oq);
        foreach (eq[i]) if (eq[i].chk) begin
            checks++;
            if (oq[i] !== eq[i]) begin
                errors++;
                $display("FAIL halt_fetch cyc %0d got %h exp %h", i, oq[i], eq[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            bus.start     = 1'(i % 2);
            bus.stop      = 1'($urandom);
            bus.mem_ready = 1'($urandom);
            #1;
            checks++;
            if (obs_all !== {b(HALTED), 37'd0}) begin
                errors++;
                $display("FAIL halted got %h exp %h", obs_all, {b(HALTED), 37'd0});
            end
        end
    endtask

    task automatic test_clear_mid();
        exp_t eq[$], oq[$];
        @(negedge clock);
        clear = 1'b0;
        #1;
        checks++;
        if (obs_all !== 56'd0) begin
            errors++;
            $display("FAIL clear_from_halt got %h exp 0", obs_all);
        end
        @(negedge clock);
        clear = 1'b1;
        bus.start = 1'b0;
        kick();
        play(SUB_I, 0, 1'b0, 4, eq, oq);  // stop after T3, DUT is now entering T4
        @(negedge clock);
        bus.start = 1'b0;
        #1;
        checks++;
        if (obs_all !== {b(ZLOWIN), 16'h0008, 16'h0000, 5'b00100}) begin
            errors++;
            $display("FAIL pre_clear_t4 got %h exp %h", obs_all,
                     {b(ZLOWIN), 16'h0008, 16'h0000, 5'b00100});
        end
        clear = 1'b0;
        #1;
        checks++;
        if (obs_all !== 56'd0) begin
            errors++;
            $display("FAIL clear_mid_t4 got %h exp 0", obs_all);
        end
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs_all !== 56'd0) begin
                errors++;
                $display("FAIL idle_after_clear got %h exp 0", obs_all);
            end
            @(negedge clock);
        end
        bus.start = 1'b1;
        #1;
        play(SUB_I, 2, 1'b0, -1, eq, oq);
        foreach (eq[i]) if (eq[i].chk) begin
            checks++;
            if (oq[i] !== eq[i]) begin
                errors++;
                $display("FAIL post_clear cyc %0d got %h exp %h", i, oq[i], eq[i]);
            end
        end
    endtask

    initial begin
        clear         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir        = '0;
        test_reset();
        test_sub();
        test_mem_wait();
        test_mul_neg_illegal();
        test_random();
        test_stop();
        test_halt();
        test_clear_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
